encoder_83: RTL and testbench

ENCODER_83 -- requirements
Module: encoder_83

---
 rtl/encoder_83_pkg.sv | 23 ++
 rtl/encoder_83_if.sv | 36 +++
 rtl/prio_enc_83.sv | 20 ++
 rtl/encoder_83.sv | 115 +++++++++++
 tb/tb_encoder_83.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/encoder_83_pkg.sv
// encoder_83 shared types and constants.
// FSM state, enable pattern, widths, bit-mask helper.
package encoder_83_pkg;

  localparam int REQ_W = 8;
  localparam int IDX_W = 3;

  localparam logic [2:0] EN_ACTIVE = 3'b100;

  // One-hot encoding so that corrupted
  // values are detectable and recoverable.
  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    SERVE = 2'b10
  } state_t;

  function automatic logic [REQ_W-1:0] bit_mask(
    input logic [IDX_W-1:0] idx
  );
    return REQ_W'(1) << idx;
  endfunction

endpackage

// File: rtl/encoder_83_if.sv
// encoder_83 request/response bundle.
// master: en, req, ack out; idx, valid, busy in. slave: reverse.
interface encoder_83_if
  import encoder_83_pkg::*;
(
  input logic clk
);

  logic [2:0]       en;
  logic [REQ_W-1:0] req;
  logic             ack;
  logic [IDX_W-1:0] idx;
  logic             valid;
  logic             busy;

  modport master (
    input  clk,
    output en,
    output req,
    output ack,
    input  idx,
    input  valid,
    input  busy
  );

  modport slave (
    input  clk,
    input  en,
    input  req,
    input  ack,
    output idx,
    output valid,
    output busy
  );

endinterface

// File: rtl/prio_enc_83.sv
// 8-to-3 highest-set-bit encoder (bit 7 wins).
// req: request lines; idx: winning index; any: some bit set.
module prio_enc_83
  import encoder_83_pkg::*;
(
  input  logic [REQ_W-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < REQ_W; i++) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/encoder_83.sv
// Snapshot priority encoder with ack-driven service.
// clk_i/rst_n_i; en_i, data_i, ack_i in; data_o, valid_o, busy_o out.
module encoder_83
  import encoder_83_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [2:0]       en_i,
  input  logic [REQ_W-1:0] data_i,
  input  logic             ack_i,
  output logic [IDX_W-1:0] data_o,
  output logic             valid_o,
  output logic             busy_o
);

  state_t           state_q;
  state_t           state_d;
  logic [REQ_W-1:0] pend_q;
  logic [REQ_W-1:0] pend_d;
  logic [IDX_W-1:0] idx_d;
  logic             valid_d;
  logic             busy_d;

  logic             en_ok;
  logic [REQ_W-1:0] pend_rem;
  logic [IDX_W-1:0] rem_idx;
  logic             rem_any;
  logic [IDX_W-1:0] in_idx;
  logic             in_any;

  assign en_ok = (en_i == EN_ACTIVE);

  // data_o already holds the bit being
  // served, so encoding pend with that
  // bit removed yields the next index.
  assign pend_rem = pend_q & ~bit_mask(data_o);

  prio_enc_83 u_pend_enc (
    .req (pend_rem),
    .idx (rem_idx),
    .any (rem_any)
  );

  prio_enc_83 u_in_enc (
    .req (data_i),
    .idx (in_idx),
    .any (in_any)
  );

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    idx_d   = data_o;
    valid_d = valid_o;
    busy_d  = busy_o;
    unique case (state_q)
      IDLE: begin
        pend_d  = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (en_ok && in_any) begin
          state_d = SERVE;
          pend_d  = data_i;
          idx_d   = in_idx;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      SERVE: begin
        if (!en_ok) begin
          state_d = IDLE;
          pend_d  = '0;
          idx_d   = '0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (ack_i) begin
          pend_d = pend_rem;
          if (rem_any) begin
            idx_d = rem_idx;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      pend_q  <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      data_o  <= idx_d;
      valid_o <= valid_d;
      busy_o  <= busy_d;
    end
  end

endmodule

// File: tb/tb_encoder_83.sv
// Scoreboard bench for encoder_83.
// Driver pushes model expectations; monitor pops and compares.
module tb_encoder_83;

  logic clk;
  logic rst_n;

  encoder_83_if bus (.clk(clk));

  encoder_83 dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .en_i    (bus.en),
    .data_i  (bus.req),
    .ack_i   (bus.ack),
    .data_o  (bus.idx),
    .valid_o (bus.valid),
    .busy_o  (bus.busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [4:0] exp_q[$];

  bit [7:0] m_set;
  bit       m_srv;
  int       m_cur;

  task automatic check(
    input string      name,
    input logic [4:0] got,
    input logic [4:0] want
  );
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got v/b/idx=%b want=%b t=%0t",
               name, got, want, $time);
    end
  endtask

  // Highest set bit = floor(log2(x)).
  function automatic int hi(input int x);
    return $clog2(x + 1) - 1;
  endfunction

  task automatic step(
    input logic       r,
    input logic [2:0] e,
    input logic [7:0] d,
    input logic       a
  );
    @(negedge clk);
    rst_n   = r;
    bus.en  = e;
    bus.req = d;
    bus.ack = a;
    if (!r) begin
      m_set = '0;
      m_srv = 1'b0;
    end else if (m_srv) begin
      if (e != 3'b100) begin
        m_set = '0;
        m_srv = 1'b0;
      end else if (a) begin
        m_set[m_cur] = 1'b0;
        if (m_set != 0) m_cur = hi(int'(m_set));
        else m_srv = 1'b0;
      end
    end else if (e == 3'b100 && d != 0) begin
      m_set = d;
      m_srv = 1'b1;
      m_cur = hi(int'(d));
    end
    exp_q.push_back(m_srv ? {2'b11, 3'(m_cur)} : 5'b0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0)
        check("out", {bus.valid, bus.busy, bus.idx},
              exp_q.pop_front());
    end
  end

  initial begin
    rst_n   = 1'b0;
    bus.en  = 3'b000;
    bus.req = 8'h00;
    bus.ack = 1'b0;
    m_set   = '0;
    m_srv   = 1'b0;
    m_cur   = 0;
    #1;
    check("reset", {bus.valid, bus.busy, bus.idx}, 5'b0);
    step(0, 3'b100, 8'hFF, 1'b0);
    step(0, 3'b100, 8'hFF, 1'b0);

    // Three-bit snapshot served in order.
    step(1, 3'b100, 8'hA4, 1'b0);
    for (int i = 0; i < 3; i++) step(1, 3'b100, 8'h00, 1'b1);
    step(1, 3'b100, 8'h00, 1'b0);

    // Long hold without ack, inputs toggling.
    step(1, 3'b100, 8'h01, 1'b0);
    for (int i = 0; i < 10; i++)
      step(1, 3'b100, 8'($urandom), 1'b0);
    step(1, 3'b100, 8'h00, 1'b1);

    // Disabled capture; abort beats ack.
    step(1, 3'b101, 8'hFF, 1'b0);
    step(1, 3'b101, 8'hFF, 1'b0);
    step(1, 3'b100, 8'hC0, 1'b0);
    step(1, 3'b000, 8'h00, 1'b1);
    step(1, 3'b100, 8'h00, 1'b0);

    // One-hot sweep.
    for (int i = 0; i < 8; i++) begin
      step(1, 3'b100, 8'(1 << i), 1'b0);
      step(1, 3'b100, 8'h00, 1'b1);
    end

    // Re-capture only one edge after return.
    step(1, 3'b100, 8'h10, 1'b0);
    step(1, 3'b100, 8'h10, 1'b1);
    step(1, 3'b100, 8'h10, 1'b0);
    step(1, 3'b100, 8'h10, 1'b0);
    step(1, 3'b100, 8'h00, 1'b1);
    step(1, 3'b100, 8'h00, 1'b0);

    // Asynchronous reset between edges.
    step(1, 3'b100, 8'hFF, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst", {bus.valid, bus.busy, bus.idx}, 5'b0);
    step(0, 3'b100, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step(1, 3'b100, 8'h00, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic       r;
      logic [2:0] e;
      logic [7:0] d;
      logic       a;
      r = ($urandom_range(0, 49) != 0);
      e = ($urandom_range(0, 7) == 0) ?
          3'($urandom_range(0, 7)) : 3'b100;
      d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      a = 1'($urandom_range(0, 1));
      step(r, e, d, a);
    end

    repeat (2) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got=%0d left want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
